// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative RV32M multiply/divide engine: shift-add multiply, restoring divide, one bit per cycle.
// Optional MULDIV_FAST_MUL_EN swaps the multiply path for a single-cycle XLEN x XLEN multiplier.
module ex_muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start_i,
   input  logic [2:0]      funct3_i,
   input  logic [XLEN-1:0] rs1_val_i,
   input  logic [XLEN-1:0] rs2_val_i,
   input  logic [4:0]      rd_i,
   input  logic            flush_i,
   output logic            stall_o,
   output logic            result_valid_o,
   output logic [XLEN-1:0] result_o,
   output logic [4:0]      rd_o
);
   localparam int CNT_W = $clog2(XLEN);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [2*XLEN-1:0]   acc_q, acc_d;
   logic [XLEN-1:0]     opb_q, opb_d;
   logic [2:0]          f3_q, f3_d;
   logic                neg_q, neg_d, negr_q, negr_d;
   logic [4:0]          op_rd_q, op_rd_d, rd_q, rd_d;
   logic [XLEN-1:0]     res_q, res_d;

   logic                take, is_div, a_sgn, b_sgn, a_neg, b_neg;
   logic                div_zero, div_ovf, special, fast;
   logic [XLEN-1:0]     a_mag, b_mag, special_res, fast_res;
   logic [XLEN:0]       mul_sum, rem_sh, diff;
   logic [2*XLEN-1:0]   step;

   // Signed magnitude post-processing shared by the iterative and single-cycle paths.
   function automatic logic [XLEN-1:0] finish_res(input logic [2:0] f3, input logic neg, input logic negr,
                                                  input logic [2*XLEN-1:0] acc);
      logic [2*XLEN-1:0] p;
      logic [XLEN-1:0]   q, r;
      p = neg ? -acc : acc;
      q = neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
      r = negr ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
      if (!f3[2]) return (f3 == 3'b000) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
      else        return f3[1] ? r : q;
   endfunction

   always_comb begin
      take        = start_i && !flush_i;
      is_div      = funct3_i[2];
      a_sgn       = (funct3_i == 3'b001) || (funct3_i == 3'b010) || (funct3_i == 3'b100) || (funct3_i == 3'b110);
      b_sgn       = (funct3_i == 3'b001) || (funct3_i == 3'b100) || (funct3_i == 3'b110);
      a_neg       = a_sgn && rs1_val_i[XLEN-1];
      b_neg       = b_sgn && rs2_val_i[XLEN-1];
      a_mag       = a_neg ? -rs1_val_i : rs1_val_i;
      b_mag       = b_neg ? -rs2_val_i : rs2_val_i;
      div_zero    = is_div && (rs2_val_i == '0);
      div_ovf     = is_div && !funct3_i[0] && (rs1_val_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_val_i == '1);
      special     = div_zero || div_ovf;
      special_res = div_zero ? (funct3_i[1] ? rs1_val_i : '1) : (funct3_i[1] ? '0 : rs1_val_i);
`ifdef MULDIV_FAST_MUL_EN
      fast        = !is_div;
      fast_res    = finish_res(funct3_i, a_neg ^ b_neg, a_neg, {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag});
`else
      fast        = 1'b0;
      fast_res    = '0;
`endif
   end

   // One iteration: multiply adds opb into the high half and shifts right; divide shifts left and trial-subtracts.
   always_comb begin
      mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
      rem_sh  = acc_q[2*XLEN-1:XLEN-1];
      diff    = rem_sh - {1'b0, opb_q};
      if (!f3_q[2])       step = {mul_sum, acc_q[XLEN-1:1]};
      else if (!diff[XLEN]) step = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      else                step = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         opb_q   <= '0;
         f3_q    <= '0;
         neg_q   <= 1'b0;
         negr_q  <= 1'b0;
         op_rd_q <= '0;
         rd_q    <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         opb_q   <= opb_d;
         f3_q    <= f3_d;
         neg_q   <= neg_d;
         negr_q  <= negr_d;
         op_rd_q <= op_rd_d;
         rd_q    <= rd_d;
         res_q   <= res_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (take) state_d = (special || fast) ? DONE : CALC;
         CALC:    if (cnt_q == CNT_W'(XLEN-1)) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (flush_i) state_d = IDLE;
   end

   always_comb begin
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      opb_d   = opb_q;
      f3_d    = f3_q;
      neg_d   = neg_q;
      negr_d  = negr_q;
      op_rd_d = op_rd_q;
      rd_d    = rd_q;
      res_d   = res_q;
      if (state_q == IDLE && take) begin
         cnt_d   = '0;
         f3_d    = funct3_i;
         neg_d   = a_neg ^ b_neg;
         negr_d  = a_neg;
         op_rd_d = rd_i;
         opb_d   = is_div ? b_mag : a_mag;
         acc_d   = {{XLEN{1'b0}}, is_div ? a_mag : b_mag};
         if (special || fast) begin
            res_d = special ? special_res : fast_res;
            rd_d  = rd_i;
         end
      end else if (state_q == CALC) begin
         cnt_d = cnt_q + CNT_W'(1);
         acc_d = step;
         if (cnt_q == CNT_W'(XLEN-1) && !flush_i) begin
            res_d = finish_res(f3_q, neg_q, negr_q, step);
            rd_d  = op_rd_q;
         end
      end
   end

   always_comb begin
      stall_o        = (state_q == IDLE && take) || (state_q == CALC);
      result_valid_o = (state_q == DONE);
      result_o       = res_q;
      rd_o           = rd_q;
   end
endmodule
